regfile_sc: RTL and testbench



---
 rtl/regfile_sc.sv | 118 +++++++++++
 tb/tb_regfile_sc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sc.sv
// regfile_sc: NREG x XLEN integer register file for the decode stage.
// Two combinational read ports, one write port, optional hard-wired zero
// entry, optional same-cycle write-to-read bypass. A clear engine zeroes one
// entry per cycle after reset or on a Clr_RF pulse; Busy_RF holds off the
// pipeline while the sweep runs.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (restarts the sweep)
//   Clr_RF     one-cycle pulse, starts a clear sweep from IDLE
//   RAddr1_RF  read address, port 1
//   RAddr2_RF  read address, port 2
//   WAddr_RF   write address
//   WrEn_RF    write enable
//   WD_RF      write data
//   RD1_RF     read data, port 1 (0 during reset and sweep)
//   RD2_RF     read data, port 2 (0 during reset and sweep)
//   Busy_RF    clear sweep in progress (registered)
//
// state | meaning
// IDLE  | normal operation, reads and writes accepted
// CLEAR | sweeping entry[cnt] to 0, writes dropped, reads forced to 0
module regfile_sc #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Clr_RF,
  input  logic [AW-1:0]   RAddr1_RF,
  input  logic [AW-1:0]   RAddr2_RF,
  input  logic [AW-1:0]   WAddr_RF,
  input  logic            WrEn_RF,
  input  logic [XLEN-1:0] WD_RF,
  output logic [XLEN-1:0] RD1_RF,
  output logic [XLEN-1:0] RD2_RF,
  output logic            Busy_RF
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [NREG];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            bypass_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = WAddr_RF;
    wr_data = WD_RF;
    unique case (state_q)
      CLEAR: begin
        // The sweep shares the single write port with writeback.
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) state_d = IDLE;
      end
      default: begin
        if (Clr_RF) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (WrEn_RF && !(ZERO_REG != 0 && WAddr_RF == '0)) begin
          wr_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  // Forwarding is suppressed when Clr_RF wins over the same-cycle write.
  assign bypass_ok = (BYPASS != 0) && WrEn_RF && !Clr_RF;

  always_comb begin
    RD1_RF = '0;
    if (!rst && state_q == IDLE) begin
      if (ZERO_REG != 0 && RAddr1_RF == '0)         RD1_RF = '0;
      else if (bypass_ok && WAddr_RF == RAddr1_RF)  RD1_RF = WD_RF;
      else                                          RD1_RF = mem_q[RAddr1_RF];
    end
  end

  always_comb begin
    RD2_RF = '0;
    if (!rst && state_q == IDLE) begin
      if (ZERO_REG != 0 && RAddr2_RF == '0)         RD2_RF = '0;
      else if (bypass_ok && WAddr_RF == RAddr2_RF)  RD2_RF = WD_RF;
      else                                          RD2_RF = mem_q[RAddr2_RF];
    end
  end

  assign Busy_RF = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_sc.sv
// Bench for regfile_sc: default instance (a), ZERO_REG=0 instance (b) sharing
// a's inputs, and a 64-bit/8-entry/no-bypass instance (c) with its own inputs.
module tb_regfile_sc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, we;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b;

  logic        clr_c, we_c;
  logic [2:0]  ra1_c, ra2_c, wa_c;
  logic [63:0] wd_c, rd1_c, rd2_c;
  logic        busy_c;

  regfile_sc u_a (
    .clk(clk), .rst(rst), .Clr_RF(clr), .RAddr1_RF(ra1), .RAddr2_RF(ra2),
    .WAddr_RF(wa), .WrEn_RF(we), .WD_RF(wd), .RD1_RF(rd1_a), .RD2_RF(rd2_a),
    .Busy_RF(busy_a));

  regfile_sc #(.ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .Clr_RF(clr), .RAddr1_RF(ra1), .RAddr2_RF(ra2),
    .WAddr_RF(wa), .WrEn_RF(we), .WD_RF(wd), .RD1_RF(rd1_b), .RD2_RF(rd2_b),
    .Busy_RF(busy_b));

  regfile_sc #(.XLEN(64), .AW(3), .BYPASS(0)) u_c (
    .clk(clk), .rst(rst), .Clr_RF(clr_c), .RAddr1_RF(ra1_c), .RAddr2_RF(ra2_c),
    .WAddr_RF(wa_c), .WrEn_RF(we_c), .WD_RF(wd_c), .RD1_RF(rd1_c), .RD2_RF(rd2_c),
    .Busy_RF(busy_c));

  int n_vec = 0;
  int n_err = 0;

  // Reference contents: index 0 models instance a (zero reg), 1 models b.
  logic [31:0] mdl [2][32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1_a, e2_a, e1_b, e2_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int k, input logic [4:0] a);
    if (k == 0 && a == 5'd0) return 32'h0;
    if (we && !clr && wa == a) return wd;
    return mdl[k][a];
  endfunction

  task automatic mdl_commit();
    if (we && !clr)
      for (int k = 0; k < 2; k++)
        if (!(k == 0 && wa == 5'd0)) mdl[k][wa] = wd;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs already driven; compare mid-cycle, then commit and advance.
  task automatic cycle_check(input string tag);
    #4;
    check({tag, "_rd1_a"}, {32'h0, rd1_a}, {32'h0, ref_rd(0, ra1)});
    check({tag, "_rd2_a"}, {32'h0, rd2_a}, {32'h0, ref_rd(0, ra2)});
    check({tag, "_rd1_b"}, {32'h0, rd1_b}, {32'h0, ref_rd(1, ra1)});
    check({tag, "_rd2_b"}, {32'h0, rd2_b}, {32'h0, ref_rd(1, ra2)});
    mdl_commit();
    tick();
  endtask

  task automatic readback_all(input string tag);
    we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      cycle_check(tag);
    end
  endtask

  // Edges until each Busy drops; -1 if it never does within the budget.
  // Any write driven during the sweep is withdrawn as soon as a goes idle.
  task automatic count_busy(output int na, output int nc);
    na = -1;
    nc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (na < 0 && !busy_a) begin
        na = i;
        we = 1'b0;
      end
      if (nc < 0 && !busy_c) nc = i;
    end
  endtask

  initial begin
    int na, nc;
    clear_model();
    rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd3; ra2 = 5'd9;
    clr_c = 1'b0; we_c = 1'b0; wa_c = '0; wd_c = '0; ra1_c = '0; ra2_c = '0;

    // Reset and initial sweep
    tick();
    tick();
    check("reset_busy_a", {63'h0, busy_a}, 64'h1);
    check("reset_busy_c", {63'h0, busy_c}, 64'h1);
    check("reset_rd1_a", {32'h0, rd1_a}, 64'h0);
    rst = 1'b0;
    #4;
    check("sweep_rd2_a", {32'h0, rd2_a}, 64'h0);
    count_busy(na, nc);
    check("init_busy_len_a", 64'(na), 64'd32);
    check("init_busy_len_c", 64'(nc), 64'd8);
    readback_all("init_zero");

    // Wide, non-bypassed instance: same-cycle read returns old data
    we_c = 1'b1; wa_c = 3'd3; wd_c = 64'h0123456789ABCDEF; ra1_c = 3'd3; ra2_c = 3'd3;
    #4;
    check("c_nobypass_rd1", rd1_c, 64'h0);
    tick();
    we_c = 1'b0;
    #4;
    check("c_readback_rd1", rd1_c, 64'h0123456789ABCDEF);
    check("c_readback_rd2", rd2_c, 64'h0123456789ABCDEF);
    tick();
    we_c = 1'b1; wd_c = 64'hFEDCBA9876543210;
    #4;
    check("c_old_data", rd1_c, 64'h0123456789ABCDEF);
    tick();
    we_c = 1'b0;
    #4;
    check("c_new_data", rd2_c, 64'hFEDCBA9876543210);
    tick();

    // Directed table: write/readback, bypass, zero register
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
                32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5,
                32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6,
                32'h12345678, 32'h0, 32'h12345678, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    foreach (vecs[i]) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #4;
      check($sformatf("vec%0d_rd1_a", i), {32'h0, rd1_a}, {32'h0, vecs[i].e1_a});
      check($sformatf("vec%0d_rd2_a", i), {32'h0, rd2_a}, {32'h0, vecs[i].e2_a});
      check($sformatf("vec%0d_rd1_b", i), {32'h0, rd1_b}, {32'h0, vecs[i].e1_b});
      check($sformatf("vec%0d_rd2_b", i), {32'h0, rd2_b}, {32'h0, vecs[i].e2_b});
      mdl_commit();
      tick();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom);
      wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = 5'($urandom);
      cycle_check("rand");
    end

    // Clear collides with a write; writes during the sweep are dropped
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i); ra1 = 5'(i); ra2 = 5'(i - 1);
      cycle_check("fill");
    end
    clr = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h55; ra1 = 5'd7; ra2 = 5'd7;
    #4;
    check("clr_prio_rd1_a", {32'h0, rd1_a}, 64'd7);
    check("clr_prio_rd2_b", {32'h0, rd2_b}, 64'd7);
    tick();
    clr = 1'b0; wd = 32'hAAAA5555;
    #4;
    check("clr_busy_rise", {63'h0, busy_a}, 64'h1);
    check("clr_rd_forced", {32'h0, rd1_a}, 64'h0);
    count_busy(na, nc);
    check("clr_busy_len_a", 64'(na), 64'd32);
    clear_model();
    readback_all("clr_zero");

    // Reset in the middle of a sweep restarts it from entry 0
    for (int i = 0; i < 50; i++) begin
      we = 1'b1; wa = 5'($urandom); wd = $urandom; ra1 = wa; ra2 = 5'($urandom);
      cycle_check("refill");
    end
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", {63'h0, busy_a}, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(na, nc);
    check("mid_rst_busy_len_a", 64'(na), 64'd32);
    check("mid_rst_busy_len_c", 64'(nc), 64'd8);
    clear_model();
    readback_all("mid_zero");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
